// File: rtl/counter_disp_core_if.sv
// -----------------------------------------------------------------------------
// counter_disp_core_if
// Pad bus between the user-project pad ring and the counter/display core.
//   io_in  : pad inputs  (bit0 count_en, bit1 up_dn, bit2 clear; rest ignored)
//   io_out : pad outputs ([9:3] seg a..g, [13:10] digit_sel, [14] ovf_led,
//            [15] run_led, [16] dir_led, [2:0] tied low)
// Modports:
//   master : pad-ring side, drives io_in and observes io_out
//   slave  : core side, samples io_in and drives io_out
// -----------------------------------------------------------------------------
interface counter_disp_core_if #(
    parameter int NUM_IOS = 17
);
    logic [NUM_IOS-1:0] io_in;
    logic [NUM_IOS-1:0] io_out;

    modport master (
        output io_in,
        input  io_out
    );

    modport slave (
        input  io_in,
        output io_out
    );
endinterface

// File: rtl/counter_disp_core.sv
// -----------------------------------------------------------------------------
// counter_disp_core
// Samples three user pads, runs a 16-bit up/down counter at a prescaled tick
// rate and shows it on a 4-digit multiplexed hex 7-segment display plus three
// status LEDs.
// Ports:
//   vccd1/vssd1 : power pins (only with USE_POWER_PINS)
//   wb_clk_i    : single clock for all logic
//   wb_rst_i    : asynchronous, active-high reset (released synchronously
//                 upstream); clears every flop, so io_out goes to zero at once
//   pads        : pad bus (slave side), io_in sampled, io_out driven
// -----------------------------------------------------------------------------
module counter_disp_core #(
    parameter int NUM_INS  = 3,
    parameter int NUM_OUTS = 14,
    parameter int NUM_IOS  = 17,
    parameter int PRESCALE = 1000000,
    parameter int SCAN_DIV = 1000
) (
`ifdef USE_POWER_PINS
    inout wire                  vccd1,
    inout wire                  vssd1,
`endif
    input  logic                wb_clk_i,
    input  logic                wb_rst_i,
    counter_disp_core_if.slave  pads
);

    localparam int PW = $clog2(PRESCALE);
    localparam int SW = $clog2(SCAN_DIV);

    // Hex glyph, active-high, returned as {g,f,e,d,c,b,a}
    function automatic logic [6:0] hex_glyph(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'h0:    seg = 7'b0111111;
            4'h1:    seg = 7'b0000110;
            4'h2:    seg = 7'b1011011;
            4'h3:    seg = 7'b1001111;
            4'h4:    seg = 7'b1100110;
            4'h5:    seg = 7'b1101101;
            4'h6:    seg = 7'b1111101;
            4'h7:    seg = 7'b0000111;
            4'h8:    seg = 7'b1111111;
            4'h9:    seg = 7'b1101111;
            4'hA:    seg = 7'b1110111;
            4'hB:    seg = 7'b1111100;
            4'hC:    seg = 7'b0111001;
            4'hD:    seg = 7'b1011110;
            4'hE:    seg = 7'b1111001;
            4'hF:    seg = 7'b1110001;
            default: seg = 7'b0000000;
        endcase
        return seg;
    endfunction

    logic [NUM_INS-1:0] sync1_q;
    logic [NUM_INS-1:0] sync2_q;
    logic               en_s;
    logic               dir_s;
    logic               clr_s;
    logic               tick_s;

    logic [PW-1:0]      presc_q, presc_d;
    logic [15:0]        count_q, count_d;
    logic               ovf_q, ovf_d;

    logic [SW-1:0]      scan_q, scan_d;
    logic [1:0]         idx_q, idx_d;

    logic [3:0]         nib_s;
    logic [3:0]         dsel_s;
    logic [6:0]         seg_q;
    logic [3:0]         dsel_q;
    logic               run_q;
    logic               dir_q;

    // Pads above the input range carry nothing for this core.
    logic               unused_ins_s;
    assign unused_ins_s = ^pads.io_in[NUM_IOS-1:NUM_INS];

    assign en_s   = sync2_q[0];
    assign dir_s  = sync2_q[1];
    assign clr_s  = sync2_q[2];
    assign tick_s = en_s && (presc_q == PW'(PRESCALE - 1));

    // Two-flop synchroniser for the three input pads
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            sync1_q <= {NUM_INS{1'b0}};
            sync2_q <= {NUM_INS{1'b0}};
        end else begin
            sync1_q <= pads.io_in[NUM_INS-1:0];
            sync2_q <= sync1_q;
        end
    end

    // Prescaler / counter / overflow next state; clear outranks a tick
    always_comb begin
        presc_d = presc_q;
        count_d = count_q;
        ovf_d   = ovf_q;
        if (clr_s) begin
            presc_d = {PW{1'b0}};
            count_d = 16'h0000;
            ovf_d   = 1'b0;
        end else begin
            if (en_s) begin
                presc_d = tick_s ? {PW{1'b0}} : presc_q + PW'(1);
            end else begin
                presc_d = presc_q;
            end
            if (tick_s) begin
                if (dir_s) begin
                    count_d = count_q + 16'd1;
                    ovf_d   = ovf_q | (count_q == 16'hFFFF);
                end else begin
                    count_d = count_q - 16'd1;
                    ovf_d   = ovf_q | (count_q == 16'h0000);
                end
            end else begin
                count_d = count_q;
                ovf_d   = ovf_q;
            end
        end
    end

    // Prescaler / counter / overflow state registers
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            presc_q <= {PW{1'b0}};
            count_q <= 16'h0000;
            ovf_q   <= 1'b0;
        end else begin
            presc_q <= presc_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
        end
    end

    // Free-running scan divider and digit index; ignores enable and clear
    always_comb begin
        if (scan_q == SW'(SCAN_DIV - 1)) begin
            scan_d = {SW{1'b0}};
            idx_d  = idx_q + 2'd1;
        end else begin
            scan_d = scan_q + SW'(1);
            idx_d  = idx_q;
        end
    end

    // Scan divider and digit index registers
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            scan_q <= {SW{1'b0}};
            idx_q  <= 2'd0;
        end else begin
            scan_q <= scan_d;
            idx_q  <= idx_d;
        end
    end

    // Digit select and nibble for the current slot, taken from the live count
    always_comb begin
        case (idx_q)
            2'd0: begin
                nib_s  = count_q[3:0];
                dsel_s = 4'b0001;
            end
            2'd1: begin
                nib_s  = count_q[7:4];
                dsel_s = 4'b0010;
            end
            2'd2: begin
                nib_s  = count_q[11:8];
                dsel_s = 4'b0100;
            end
            2'd3: begin
                nib_s  = count_q[15:12];
                dsel_s = 4'b1000;
            end
            default: begin
                nib_s  = 4'h0;
                dsel_s = 4'b0001;
            end
        endcase
    end

    // Output registers: segments and digit select share one edge so they
    // always change together; LEDs follow the synchronised pads
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            seg_q  <= 7'b0000000;
            dsel_q <= 4'b0000;
            run_q  <= 1'b0;
            dir_q  <= 1'b0;
        end else begin
            seg_q  <= hex_glyph(nib_s);
            dsel_q <= dsel_s;
            run_q  <= en_s;
            dir_q  <= dir_s;
        end
    end

    // ovf_q is itself a flop, so it drives its LED directly
    assign pads.io_out = {dir_q, run_q, ovf_q, dsel_q, seg_q, 3'b000};

endmodule

// File: doc/counter_disp_core.md
Name: counter_disp_core

Overview:
- Core of the counter-with-display user project. Samples 3 user-pad inputs and runs a 16-bit up/down counter at a prescaled tick rate.
- Drives a 4-digit multiplexed hex 7-segment display plus 3 status LEDs on 14 output pads.
- Its io_out bus feeds the same pad ring whose io_oeb pattern the tie-off block fixes: pads [2:0] are inputs, pads [16:3] are outputs.

Parameters:
- NUM_INS, 3, number of input pads, occupying io_in[NUM_INS-1:0].
- NUM_OUTS, 14, number of output pads, occupying io_out[NUM_IOS-1:NUM_INS].
- NUM_IOS, 17, total pads; must equal NUM_INS+NUM_OUTS.
- PRESCALE, 1000000, wb_clk_i cycles per count tick; minimum 2.
- SCAN_DIV, 1000, wb_clk_i cycles per display digit slot; minimum 2.

Ports:
- wb_clk_i  input  1  single clock for all logic.
- wb_rst_i  input  1  asynchronous, active-high reset.
- vccd1 / vssd1  inout  1  power pins, present only under USE_POWER_PINS.
- io_in  input  NUM_IOS  pad inputs:
  - bit0 count_en
  - bit1 up_dn (1 = up)
  - bit2 clear
  - bits above NUM_INS-1 are ignored.
- io_out  output  NUM_IOS  pad outputs:
  - [2:0] = 0
  - [9:3] = seg a..g
  - [13:10] = digit_sel[3:0]
  - [14] = ovf_led
  - [15] = run_led
  - [16] = dir_led

Behaviour:
- Reset (async assert, sync release):
  - all flops cleared; io_out = 0.
  - count = 0x0000, ovf = 0, prescaler = 0, scan counter = 0, digit index = 0.
- Input sync: each of io_in[2:0] passes through a 2-flop synchroniser. Registered values en_s, dir_s, clr_s lag the pads by 2 cycles. No debounce.
- Prescaler:
  - counts 0..PRESCALE-1 while en_s=1, then wraps.
  - tick is a 1-cycle pulse when prescaler = PRESCALE-1.
  - holds its value while en_s=0.
- Counter update, evaluated each cycle in priority order:
  - clr_s=1: count <= 0, ovf <= 0, prescaler <= 0. Clear wins over a simultaneous tick.
  - else tick & dir_s=1: count <= count+1; on 0xFFFF->0x0000 ovf <= 1.
  - else tick & dir_s=0: count <= count-1; on 0x0000->0xFFFF ovf <= 1.
  - ovf is sticky; only clear or reset drops it.
  - a direction change mid-prescale applies at the next tick.
- Display scan:
  - scan counter runs continuously, independent of en_s and clr_s, 0..SCAN_DIV-1.
  - at SCAN_DIV-1 the digit index advances 0->1->2->3->0.
  - digit_sel is one-hot, registered: index 0 -> 4'b0001 shows count[3:0]; index 3 -> 4'b1000 shows count[15:12].
  - segments are active-high, registered in the same cycle as digit_sel, so the two always change together.
  - segment patterns are standard hex glyphs (bit order a..g = io_out[3..9]):
    - 0=0111111, 1=0000110, 2=1011011, 3=1001111
    - 4=1100110, 5=1101101, 6=1111101, 7=0000111
    - 8=1111111, 9=1101111, A=1110111, b=1111100
    - C=0111001, d=1011110, E=1111001, F=1110001
  - the displayed nibble is sampled from the live count each cycle. A count change appears on the currently selected digit one cycle later.
  - digit_sel is never all-zero after the first post-reset cycle, and never has two bits set.
- Status LEDs (registered):
  - run_led = en_s
  - dir_led = dir_s
  - ovf_led = ovf
- Latency:
  - pad edge -> en_s/dir_s/clr_s: 2 cycles.
  - clr_s -> count/LEDs updated: +1 cycle.
  - tick -> count: 1 cycle.
  - count -> segments on the selected digit: 1 cycle.
- Reset mid-operation: immediate async clear of everything, including the scan position; output restarts at digit 0.
- io_out[2:0] is driven constant 0.

Test Plan (PRESCALE=4, SCAN_DIV=2 unless noted):
- Reset: assert wb_rst_i mid-count -> io_out = 17'h0 within the same cycle. After release, digit_sel = 0001 and seg = 0111111 ("0").
- Up count: count_en=1, up_dn=1 for 40 cycles -> count increments every 4 cycles; run_led=1, dir_led=1; digit0 shows 1, 2, 3, ...
- Wrap up: preload the count path to 0xFFFE via force, up for 2 ticks -> count 0x0000, ovf_led=1 and stays set after further ticks.
- Wrap down: from 0x0000 with up_dn=0, one tick -> 0xFFFF, ovf_led=1; all four digits scan "F" (1110001).
- Clear vs tick: assert clear on the same cycle that tick fires -> count=0x0000, ovf=0, no increment. Clear held 10 cycles -> count stays 0 while the scan keeps rotating.
- Scan: count=0x1A3F, SCAN_DIV=3 -> digit_sel cycles 0001, 0010, 0100, 1000, each held 3 cycles, with seg 1110001 (F), 1001111 (3), 1110111 (A), 0000110 (1) respectively; never two bits set.
